prbs_checker: RTL and testbench
===============================

# prbs_checker

Serial PRBS checker: the receiving end of the team's LFSR bit-stream generator. It consumes one bit per enabled cycle and self-synchronises its 8-bit Fibonacci LFSR model from the incoming bits. It then compares every subsequent bit against the model's prediction and reports lock state, per-bit error pulses and saturating bit/error counts. It sits on the slowed clock domain (`cclk` at top level) beside the pattern-detector FSM and counter.

## Interface
Parameters:
- `LFSR_W`, 8: LFSR length in bits.
- `TAPS`, 8'hB8: feedback tap mask (x^8+x^6+x^5+x^4+1); must match the generator.
- `WIN`, 32: loss-of-lock observation window, in checked bits.
- `ERR_LIMIT`, 4: errors within one window that force loss of lock.

Ports:
- `clk`, input, 1: clock; all state changes on rising edge.
- `rst_n`, input, 1: reset; one clock, reset asynchronous and active-low.
- `sh_en`, input, 1: bit valid; `in_bit` is accepted on any edge where `sh_en`=1.
- `in_bit`, input, 1: received serial bit (generator MSB output).
- `clr`, input, 1: synchronous clear of `bit_count`/`err_count`; does not affect lock.
- `locked`, output, 1: high while in CHECK.
- `err_pulse`, output, 1: one-cycle pulse, registered, on a mismatched checked bit.
- `lock_lost`, output, 1: one-cycle pulse on CHECK→SEED transition.
- `bit_count`, output, 16: checked bits since reset/clr, saturates at 16'hFFFF.
- `err_count`, output, 16: mismatches since reset/clr, saturates at 16'hFFFF.

## Operation
- Window register `r[LFSR_W-1:0]`, r[0] = most recent bit. Every accepted bit updates r ← {r[LFSR_W-2:0], in_bit}, in every state. The received bit is used, not the prediction (self-synchronising).
- Prediction for the accepted bit: `exp = ^(r & TAPS)`, using r before the shift.
- State SEED (reset state):
  - Counts accepted bits in `fill`, 0..LFSR_W.
  - When `fill` reaches LFSR_W: if the new r ≠ 0, go to CHECK; if r = 0, clear `fill` and stay in SEED. All-zero is the LFSR lock-up state and is never accepted as lock.
  - No comparison is made and counters are untouched in SEED.
- State CHECK:
  - Each accepted bit increments `bit_count` and `win_cnt`.
  - If `in_bit ≠ exp`: `err_pulse`=1, increment `err_count` and `win_err`.
  - When `win_cnt` reaches WIN, both window counters reset to 0.
  - If `win_err` (including the current error) reaches ERR_LIMIT before the window closes: go to SEED, `fill`=0, pulse `lock_lost`. The error that triggers loss of lock is still counted.
- `sh_en`=0: no state, counter or window change; pulse outputs low.
- `clr` has priority over a same-cycle increment: both counts become 0. The bit is still checked, and lock logic still runs.
- Both counters saturate and never wrap.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `lock_lost`=0, `bit_count`=0, `err_count`=0, r=0, `fill`=0, state=SEED.
- Asynchronous reset mid-operation returns all of the above immediately, regardless of `sh_en`.
- Bit accepted at edge N: `err_pulse`/`lock_lost`, the counters and `locked` all reflect that bit after edge N. Latency is one cycle; no combinational input→output path.
- Lock acquisition: `locked` rises after the edge accepting the LFSR_W-th seed bit, provided r ≠ 0.
- First compared bit is the one accepted after `locked` rises.
- `lock_lost` and the falling edge of `locked` occur after the same edge.

## Test plan
- Reset, then the generator stream (seed 8'h01, TAPS 8'hB8) with `sh_en`=1 every cycle -> `locked`=1 after the 8th edge; after 255 more bits, `bit_count`=255, `err_count`=0, no `err_pulse`.
- Locked stream with bit 100 inverted -> `err_pulse` asserted on exactly the cycles where the flipped bit enters the prediction taps. `err_count` equals that pulse count; `locked` stays 1.
- All-zero input for 40 bits -> `locked` stays 0, counters stay 0. Then the valid stream -> lock 8 bits later.
- Locked; invert 4 bits within a 32-bit window -> `lock_lost` pulses once, `locked`=0. Re-locks 8 clean bits later; `err_count` includes the 4th error.
- `sh_en` toggled 1/0 every cycle on a valid stream -> identical counts to the continuous case at half rate. Pulses occur only on enabled cycles.
- `clr` coincident with an error; then `err_count` preloaded to 16'hFFFF via a long error stream -> after `clr` both counts are 0. Further errors leave the count at 16'hFFFF. Async reset asserted mid-CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker
// Receiving end of the LFSR bit-stream generator. A window register holds the
// most recent LFSR_W received bits. In SEED the checker fills that window.
// Once the window is full and non-zero it moves to CHECK. In CHECK every
// accepted bit is compared against the Fibonacci feedback of the window.
// Too many errors inside one observation window drop it back to SEED.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   sh_en      bit valid; in_bit is accepted on edges where sh_en=1
//   in_bit     received serial bit (generator MSB output)
//   clr        synchronous clear of bit_count/err_count (lock unaffected)
//   locked     high while in CHECK
//   err_pulse  one-cycle pulse on a mismatched checked bit
//   lock_lost  one-cycle pulse on the CHECK -> SEED transition
//   bit_count  checked bits since reset/clr, saturating
//   err_count  mismatches since reset/clr, saturating
module prbs_checker #(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] TAPS      = 8'hB8,
  parameter int                WIN       = 32,
  parameter int                ERR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sh_en,
  input  logic        in_bit,
  input  logic        clr,
  output logic        locked,
  output logic        err_pulse,
  output logic        lock_lost,
  output logic [15:0] bit_count,
  output logic [15:0] err_count
);

  localparam int FILL_W = $clog2(LFSR_W + 1);
  localparam int WIN_W  = $clog2(WIN + 1);
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(WIN);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(ERR_LIMIT);

  typedef enum logic {SEED, CHECK} state_t;

  state_t              state_reg,     state_next;
  logic [LFSR_W-1:0]   r_reg,         r_next;
  logic [FILL_W-1:0]   fill_reg,      fill_next;
  logic [WIN_W-1:0]    win_cnt_reg,   win_cnt_next;
  logic [ERR_W-1:0]    win_err_reg,   win_err_next;
  logic                err_pulse_reg, err_pulse_next;
  logic                lock_lost_reg, lock_lost_next;
  logic [15:0]         bit_count_reg, bit_count_next;
  logic [15:0]         err_count_reg, err_count_next;

  logic [LFSR_W-1:0]   r_shift;
  logic                exp_bit;
  logic                mismatch;
  logic [WIN_W-1:0]    win_cnt_inc;
  logic [ERR_W-1:0]    win_err_inc;
  logic                bit_inc;
  logic                err_inc;

  // The received bit (not the prediction) enters the window, so a single
  // corrupted bit disturbs at most one window's worth of predictions.
  assign r_shift     = {r_reg[LFSR_W-2:0], in_bit};
  assign exp_bit     = ^(r_reg & TAPS);
  assign mismatch    = in_bit ^ exp_bit;
  assign win_cnt_inc = win_cnt_reg + WIN_W'(1);
  assign win_err_inc = win_err_reg + ERR_W'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEED;
      r_reg         <= '0;
      fill_reg      <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      err_pulse_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
      bit_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      fill_reg      <= fill_next;
      win_cnt_reg   <= win_cnt_next;
      win_err_reg   <= win_err_next;
      err_pulse_reg <= err_pulse_next;
      lock_lost_reg <= lock_lost_next;
      bit_count_reg <= bit_count_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    r_next         = r_reg;
    fill_next      = fill_reg;
    win_cnt_next   = win_cnt_reg;
    win_err_next   = win_err_reg;
    err_pulse_next = 1'b0;
    lock_lost_next = 1'b0;
    bit_inc        = 1'b0;
    err_inc        = 1'b0;

    if (sh_en) begin
      r_next = r_shift;
      case (state_reg)
        SEED: begin
          if (fill_reg == FILL_LAST) begin
            // Window just filled; all-zero is the LFSR lock-up state and is
            // never taken as a valid seed, so start refilling instead.
            fill_next = '0;
            if (r_shift != '0) begin
              state_next   = CHECK;
              win_cnt_next = '0;
              win_err_next = '0;
            end
          end else begin
            fill_next = fill_reg + FILL_W'(1);
          end
        end
        CHECK: begin
          bit_inc        = 1'b1;
          err_inc        = mismatch;
          err_pulse_next = mismatch;
          // Error limit is tested before window closure so an error on the
          // closing bit still counts toward this window.
          if (win_err_inc == ERR_MAX) begin
            state_next     = SEED;
            fill_next      = '0;
            win_cnt_next   = '0;
            win_err_next   = '0;
            lock_lost_next = 1'b1;
          end else if (win_cnt_inc == WIN_MAX) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_inc;
            win_err_next = win_err_inc;
          end
        end
        default: state_next = SEED;
      endcase
    end

    // Clear wins over a same-cycle increment; counts saturate at all-ones.
    bit_count_next = bit_count_reg;
    err_count_next = err_count_reg;
    if (clr) begin
      bit_count_next = '0;
      err_count_next = '0;
    end else begin
      if (bit_inc && (bit_count_reg != 16'hFFFF))
        bit_count_next = bit_count_reg + 16'd1;
      if (err_inc && (err_count_reg != 16'hFFFF))
        err_count_next = err_count_reg + 16'd1;
    end
  end

  assign locked    = (state_reg == CHECK);
  assign err_pulse = err_pulse_reg;
  assign lock_lost = lock_lost_reg;
  assign bit_count = bit_count_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
// Drives prbs_checker with generator streams (clean, corrupted, gated,
// randomised) and compares every cycle against a bit-history reference model.
// A second instance with a large error limit is used for counter saturation.
module tb_prbs_checker;

  localparam int          WINW    = 32;
  localparam int          LIM     = 4;
  localparam logic [7:0]  TB_TAPS = 8'hB8;

  logic        clk = 1'b0;
  logic        rst_n, sh_en, in_bit, clr;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] bit_count, err_count;

  logic        sat_rst_n, sat_en, sat_bit, sat_clr;
  logic        sat_locked, sat_err_pulse, sat_lock_lost;
  logic [15:0] sat_bit_count, sat_err_count;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sh_en     (sh_en),
    .in_bit    (in_bit),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .lock_lost (lock_lost),
    .bit_count (bit_count),
    .err_count (err_count)
  );

  prbs_checker #(.ERR_LIMIT(64)) u_sat (
    .clk       (clk),
    .rst_n     (sat_rst_n),
    .sh_en     (sat_en),
    .in_bit    (sat_bit),
    .clr       (sat_clr),
    .locked    (sat_locked),
    .err_pulse (sat_err_pulse),
    .lock_lost (sat_lock_lost),
    .bit_count (sat_bit_count),
    .err_count (sat_err_count)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_pulses = 0;
  int n_lost   = 0;

  task automatic check(input string tag, input int obs, input int want);
    n_total++;
    if (obs != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, want, $time);
    end
  endtask

  // ---------------- generator (seed 8'h01, MSB out) ----------------
  logic [7:0] g;
  task automatic gen_next(output bit b);
    b = g[7];
    g = {g[6:0], ^(g & TB_TAPS)};
  endtask

  // ---------------- reference model ----------------
  // The received history is kept as a plain list of bits; a prediction is
  // the XOR of the history bits sitting at the tap distances behind it.
  bit hist[$];
  bit m_locked, m_pulse, m_lost;
  int m_fill, m_win_bits, m_win_errs, m_bits, m_errs;

  function automatic bit hb(int k);
    if (k < 0 || k >= hist.size()) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_locked = 0; m_pulse = 0; m_lost = 0;
    m_fill = 0; m_win_bits = 0; m_win_errs = 0; m_bits = 0; m_errs = 0;
  endtask

  task automatic model_accept(input bit b);
    int n;
    bit p;
    bit nz;
    n = hist.size();
    p = 1'b0;
    for (int j = 0; j < 8; j++)
      if (TB_TAPS[j]) p ^= hb(n - 1 - j);
    hist.push_back(b);
    if (!m_locked) begin
      m_fill++;
      if (m_fill == 8) begin
        m_fill = 0;
        nz = 1'b0;
        for (int k = 0; k < 8; k++) nz |= hb(n - k);
        if (nz) begin m_locked = 1; m_win_bits = 0; m_win_errs = 0; end
      end
    end else begin
      if (m_bits < 65535) m_bits++;
      m_win_bits++;
      if (b != p) begin
        m_pulse = 1;
        m_win_errs++;
        if (m_errs < 65535) m_errs++;
      end
      if (m_win_errs >= LIM) begin
        m_locked = 0; m_fill = 0; m_lost = 1; m_win_bits = 0; m_win_errs = 0;
      end else if (m_win_bits == WINW) begin
        m_win_bits = 0; m_win_errs = 0;
      end
    end
  endtask

  // One cycle on the main DUT, then compare every output with the model.
  task automatic step(input bit en, input bit b, input bit c);
    sh_en = en; in_bit = b; clr = c;
    @(posedge clk); #1;
    m_pulse = 0; m_lost = 0;
    if (en) model_accept(b);
    if (c) begin m_bits = 0; m_errs = 0; end
    check("locked",    locked,    m_locked);
    check("err_pulse", err_pulse, m_pulse);
    check("lock_lost", lock_lost, m_lost);
    check("bit_count", bit_count, m_bits);
    check("err_count", err_count, m_errs);
    if (err_pulse) n_pulses++;
    if (lock_lost) n_lost++;
  endtask

  task automatic gen_step(input bit flip, input bit c);
    bit b;
    gen_next(b);
    step(1'b1, b ^ flip, c);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked,    0);
    check({tag, "_pulse"},  err_pulse, 0);
    check({tag, "_lost"},   lock_lost, 0);
    check({tag, "_bits"},   bit_count, 0);
    check({tag, "_errs"},   err_count, 0);
  endtask

  // Reset asserted between edges with sh_en high; outputs must clear at once.
  task automatic async_reset(input string tag);
    @(posedge clk); #2;
    sh_en = 1'b1; in_bit = 1'b1; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic sat_step(input bit b, input bit c);
    sat_en = 1'b1; sat_bit = b; sat_clr = c;
    @(posedge clk); #1;
  endtask

  initial begin
    int e0, p0, l0;
    bit b;
    rst_n = 1'b0; sh_en = 1'b0; in_bit = 1'b0; clr = 1'b0;
    sat_rst_n = 1'b0; sat_en = 1'b0; sat_bit = 1'b0; sat_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1; sat_rst_n = 1'b1;

    // Clean generator stream: lock after 8 bits, then 255 clean checks.
    g = 8'h01;
    for (int i = 0; i < 8 + 255; i++) begin
      gen_step(1'b0, 1'b0);
      if (i == 6) check("pre_lock", locked, 0);
      if (i == 7) check("lock8", locked, 1);
    end
    check("clean_bits", bit_count, 255);
    check("clean_errs", err_count, 0);
    check("clean_pulses", n_pulses, 0);
    $display("phase clean: total=%0d bad=%0d", n_total, n_bad);

    // One flipped bit placed so its five error predictions straddle a
    // window boundary (2 + 3 errors), keeping lock.
    p0 = n_pulses; e0 = err_count;
    for (int i = 0; i < 60; i++) gen_step(i == 28, 1'b0);
    check("flip_pulses", n_pulses - p0, 5);
    check("flip_errs", err_count - e0, 5);
    check("flip_locked", locked, 1);
    $display("phase flip: total=%0d bad=%0d", n_total, n_bad);

    async_reset("areset1");

    // All-zero input never locks, then the real stream locks 8 bits later.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    check("zero_locked", locked, 0);
    check("zero_bits", bit_count, 0);
    g = 8'h01;
    for (int i = 0; i < 60; i++) begin
      gen_step(1'b0, 1'b0);
      if (i == 7) check("zero_relock", locked, 1);
    end
    $display("phase zero: total=%0d bad=%0d", n_total, n_bad);

    // Four consecutive bad bits inside one window force loss of lock.
    l0 = n_lost; e0 = m_errs;
    for (int i = 0; i < 4; i++) gen_step(1'b1, 1'b0);
    check("lost_pulse", n_lost - l0, 1);
    check("lost_locked", locked, 0);
    check("lost_errs", err_count, e0 + 4);
    for (int i = 0; i < 8; i++) gen_step(1'b0, 1'b0);
    check("relock", locked, 1);
    for (int i = 0; i < 20; i++) gen_step(1'b0, 1'b0);
    check("relock_errs", err_count, e0 + 4);
    $display("phase lose: total=%0d bad=%0d", n_total, n_bad);

    // Half-rate enable: same counts as continuous operation.
    async_reset("areset2");
    g = 8'h01;
    for (int i = 0; i < 2 * (8 + 100); i++) begin
      if (i % 2 == 0) gen_step(1'b0, 1'b0);
      else step(1'b0, 1'b1, 1'b0);
    end
    check("half_bits", bit_count, 100);
    check("half_errs", err_count, 0);
    $display("phase half: total=%0d bad=%0d", n_total, n_bad);

    // Randomised enable, sparse bit errors and occasional clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        gen_next(b);
        step(1'b1, b ^ ($urandom_range(0, 39) == 0), $urandom_range(0, 49) == 0);
      end else begin
        step(1'b0, $urandom_range(0, 1), $urandom_range(0, 49) == 0);
      end
    end
    $display("phase random: total=%0d bad=%0d", n_total, n_bad);

    // Clear in the same cycle as an error.
    async_reset("areset3");
    g = 8'h01;
    for (int i = 0; i < 18; i++) gen_step(1'b0, 1'b0);
    gen_step(1'b1, 1'b1);
    check("clr_pulse", err_pulse, 1);
    check("clr_errs", err_count, 0);
    check("clr_bits", bit_count, 0);
    check("clr_locked", locked, 1);
    gen_step(1'b0, 1'b0);
    check("after_clr_bits", bit_count, 1);
    async_reset("areset4");
    $display("phase clr: total=%0d bad=%0d", n_total, n_bad);

    // Saturation: an inverted stream mispredicts every checked bit, and the
    // large error limit on this instance keeps it locked throughout.
    sh_en = 1'b0;
    g = 8'h01;
    for (int i = 0; i < 8; i++) begin gen_next(b); sat_step(~b, 1'b0); end
    check("sat_locked", sat_locked, 1);
    for (int i = 0; i < 65540; i++) begin
      gen_next(b);
      sat_step(~b, 1'b0);
      if (i == 65533) check("sat_pre_errs", sat_err_count, 65534);
    end
    check("sat_errs", sat_err_count, 65535);
    check("sat_bits", sat_bit_count, 65535);
    check("sat_pulse", sat_err_pulse, 1);
    check("sat_lost", sat_lock_lost, 0);
    gen_next(b); sat_step(~b, 1'b1);
    check("sat_clr_errs", sat_err_count, 0);
    check("sat_clr_bits", sat_bit_count, 0);
    for (int i = 0; i < 3; i++) begin gen_next(b); sat_step(~b, 1'b0); end
    check("sat_post_errs", sat_err_count, 3);
    sat_en = 1'b0;
    $display("phase sat: total=%0d bad=%0d", n_total, n_bad);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
